// File: rtl/fib_access_arbiter_if.sv
// Bundle of requester, FIB and response signals around the FIB access arbiter.
// The arbiter takes the master side; the requesters/FIB/consumer take the slave side.
interface fib_access_arbiter_if;
  logic        pit_req_valid;
  logic [63:0] pit_req_prefix;
  logic [5:0]  pit_req_len;
  logic        pit_req_ready;
  logic        in_req_valid;
  logic [63:0] in_req_prefix;
  logic [5:0]  in_req_len;
  logic        in_req_ready;
  logic [63:0] fib_prefix;
  logic [5:0]  fib_len;
  logic        fib_out_bit;
  logic        fib_data_ready;
  logic        fib_done;
  logic        fib_rejected;
  logic [63:0] fib_match_prefix;
  logic [5:0]  fib_match_len;
  logic        rsp_valid;
  logic        rsp_to_pit;
  logic [63:0] rsp_prefix;
  logic [5:0]  rsp_len;
  logic [1:0]  rsp_status;
  logic        rsp_ack;
  logic        busy;
  logic [7:0]  timeout_count;

  modport master (
    input  pit_req_valid, pit_req_prefix, pit_req_len,
    input  in_req_valid, in_req_prefix, in_req_len,
    input  fib_done, fib_rejected, fib_match_prefix, fib_match_len,
    input  rsp_ack,
    output pit_req_ready, in_req_ready,
    output fib_prefix, fib_len, fib_out_bit, fib_data_ready,
    output rsp_valid, rsp_to_pit, rsp_prefix, rsp_len, rsp_status,
    output busy, timeout_count
  );

  modport slave (
    output pit_req_valid, pit_req_prefix, pit_req_len,
    output in_req_valid, in_req_prefix, in_req_len,
    output fib_done, fib_rejected, fib_match_prefix, fib_match_len,
    output rsp_ack,
    input  pit_req_ready, in_req_ready,
    input  fib_prefix, fib_len, fib_out_bit, fib_data_ready,
    input  rsp_valid, rsp_to_pit, rsp_prefix, rsp_len, rsp_status,
    input  busy, timeout_count
  );
endinterface

// File: rtl/fib_access_arbiter.sv
// Round-robin arbiter sharing the single FIB port between the PIT path and the
// incoming-data path; one request in flight, tagged response with timeout.
module fib_access_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  fib_access_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pit_next_q, pit_next_d;
  logic               req_pit_q, req_pit_d;
  logic [63:0]        req_prefix_q, req_prefix_d;
  logic [5:0]         req_len_q, req_len_d;
  logic [63:0]        rsp_prefix_q, rsp_prefix_d;
  logic [5:0]         rsp_len_q, rsp_len_d;
  logic [1:0]         rsp_status_q, rsp_status_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               grant_pit;
  logic               grant_in;
  logic               fib_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pit_next_q   <= 1'b1;
      req_pit_q    <= 1'b0;
      req_prefix_q <= '0;
      req_len_q    <= '0;
      rsp_prefix_q <= '0;
      rsp_len_q    <= '0;
      rsp_status_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pit_next_q   <= pit_next_d;
      req_pit_q    <= req_pit_d;
      req_prefix_q <= req_prefix_d;
      req_len_q    <= req_len_d;
      rsp_prefix_q <= rsp_prefix_d;
      rsp_len_q    <= rsp_len_d;
      rsp_status_q <= rsp_status_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pit_next_d   = pit_next_q;
    req_pit_d    = req_pit_q;
    req_prefix_d = req_prefix_q;
    req_len_d    = req_len_q;
    rsp_prefix_d = rsp_prefix_q;
    rsp_len_d    = rsp_len_q;
    rsp_status_d = rsp_status_q;
    tmo_cnt_d    = tmo_cnt_q;
    grant_pit    = 1'b0;
    grant_in     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pit_req_valid && (!bus.in_req_valid || pit_next_q)) begin
          grant_pit = 1'b1;
        end else if (bus.in_req_valid) begin
          grant_in = 1'b1;
        end
        if (grant_pit || grant_in) begin
          req_pit_d    = grant_pit;
          req_prefix_d = grant_pit ? bus.pit_req_prefix : bus.in_req_prefix;
          req_len_d    = grant_pit ? bus.pit_req_len : bus.in_req_len;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion takes priority over a timeout expiring in the same cycle.
        if (bus.fib_done) begin
          rsp_status_d = {1'b0, bus.fib_rejected};
          rsp_prefix_d = req_pit_q ? bus.fib_match_prefix : req_prefix_q;
          rsp_len_d    = req_pit_q ? bus.fib_match_len : req_len_q;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          rsp_status_d = 2'b10;
          rsp_prefix_d = req_prefix_q;
          rsp_len_d    = req_len_q;
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ack) begin
          pit_next_d = ~req_pit_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fib_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Ready is combinational from valid, so mask it while reset is held.
  assign bus.pit_req_ready  = grant_pit & ~rst;
  assign bus.in_req_ready   = grant_in & ~rst;
  assign bus.fib_prefix     = fib_active ? req_prefix_q : '0;
  assign bus.fib_len        = fib_active ? req_len_q : '0;
  assign bus.fib_out_bit    = (state_q == ST_ISSUE) & req_pit_q;
  assign bus.fib_data_ready = (state_q == ST_ISSUE) & ~req_pit_q;
  assign bus.rsp_valid      = (state_q == ST_RESP);
  assign bus.rsp_to_pit     = (state_q == ST_RESP) & req_pit_q;
  assign bus.rsp_prefix     = rsp_prefix_q;
  assign bus.rsp_len        = rsp_len_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.timeout_count  = tmo_cnt_q;

endmodule

// File: tb/tb_fib_access_arbiter.sv
// Self-checking bench for fib_access_arbiter: directed scenarios then random
// transactions, all compared against a transaction-level reference model.
module tb_fib_access_arbiter;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic m_pit_next;
  int   m_tmo;

  fib_access_arbiter_if bus ();

  fib_access_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE to the ack edge. k = cycles after the strobe
  // at which fib_done pulses (0 = never).
  task automatic run_txn(input logic pv, input logic iv,
                         input logic [63:0] pp, input logic [5:0] pl,
                         input logic [63:0] ip, input logic [5:0] il,
                         input int k, input logic rej,
                         input logic [63:0] mp, input logic [5:0] ml,
                         input int ack_dly);
    logic        gp;
    logic [63:0] rp;
    logic [5:0]  rl;
    logic        done_eff;
    int          rsp_at;
    int          c;
    logic        got;
    logic        wait_ok;
    logic        hold_ok;
    logic [1:0]  es;
    logic [63:0] ep;
    logic [5:0]  el;

    @(negedge clk);
    bus.rsp_ack        = 1'b0;
    bus.pit_req_valid  = pv;
    bus.pit_req_prefix = pp;
    bus.pit_req_len    = pl;
    bus.in_req_valid   = iv;
    bus.in_req_prefix  = ip;
    bus.in_req_len     = il;
    bus.fib_done       = 1'($urandom);
    #1;
    gp = pv && (!iv || m_pit_next);
    rp = gp ? pp : ip;
    rl = gp ? pl : il;
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    check("idle_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("pit_ready", {63'd0, bus.pit_req_ready}, {63'd0, gp});
    check("in_ready", {63'd0, bus.in_req_ready}, {63'd0, iv && !gp});

    // ISSUE: the requester's inputs change; the latched copy must be used.
    @(negedge clk);
    if (gp) bus.pit_req_valid = 1'b0;
    else    bus.in_req_valid  = 1'b0;
    bus.pit_req_prefix = {$urandom, $urandom};
    bus.in_req_prefix  = {$urandom, $urandom};
    bus.pit_req_len    = 6'($urandom);
    bus.in_req_len     = 6'($urandom);
    bus.fib_done       = 1'($urandom);
    bus.rsp_ack        = 1'b1;
    #1;
    check("strobe_pit", {63'd0, bus.fib_out_bit}, {63'd0, gp});
    check("strobe_in", {63'd0, bus.fib_data_ready}, {63'd0, !gp});
    check("fib_prefix", bus.fib_prefix, rp);
    check("fib_len", {58'd0, bus.fib_len}, {58'd0, rl});
    check("issue_busy_ready", {61'd0, bus.busy, bus.pit_req_ready, bus.in_req_ready}, 64'd4);

    done_eff = (k >= 1) && (k <= TIMEOUT - 1);
    rsp_at   = done_eff ? k + 1 : TIMEOUT;
    c = 0;
    got = 1'b0;
    wait_ok = 1'b1;
    while (!got && c < TIMEOUT + 8) begin
      c++;
      @(negedge clk);
      bus.rsp_ack          = 1'b0;
      bus.fib_done         = (c == k);
      bus.fib_rejected     = (c == k) ? rej : 1'($urandom);
      bus.fib_match_prefix = (c == k) ? mp : {$urandom, $urandom};
      bus.fib_match_len    = (c == k) ? ml : 6'($urandom);
      #1;
      if (bus.rsp_valid) got = 1'b1;
      else if (bus.fib_out_bit || bus.fib_data_ready || bus.fib_prefix !== rp ||
               bus.fib_len !== rl || !bus.busy) wait_ok = 1'b0;
    end
    bus.fib_done = 1'b0;
    check("wait_outputs", {63'd0, wait_ok}, 64'd1);
    check("rsp_cycle", 64'(c), 64'(rsp_at));

    es = done_eff ? {1'b0, rej} : 2'b10;
    ep = (done_eff && gp) ? mp : rp;
    el = (done_eff && gp) ? ml : rl;
    if (!done_eff && m_tmo < 255) m_tmo++;
    check("rsp_to_pit", {63'd0, bus.rsp_to_pit}, {63'd0, gp});
    check("rsp_status", {62'd0, bus.rsp_status}, {62'd0, es});
    check("rsp_prefix", bus.rsp_prefix, ep);
    check("rsp_len", {58'd0, bus.rsp_len}, {58'd0, el});
    check("timeout_count", {56'd0, bus.timeout_count}, 64'(m_tmo));
    check("resp_fib_idle", {bus.fib_prefix[63:6], bus.fib_prefix[5:0] | bus.fib_len}, 64'd0);

    hold_ok = 1'b1;
    for (int h = 0; h < ack_dly; h++) begin
      @(negedge clk);
      bus.fib_done     = 1'($urandom);
      bus.fib_rejected = 1'($urandom);
      #1;
      if (!bus.rsp_valid || !bus.busy || bus.pit_req_ready || bus.in_req_ready ||
          bus.rsp_to_pit !== gp || bus.rsp_status !== es ||
          bus.rsp_prefix !== ep || bus.rsp_len !== el) hold_ok = 1'b0;
    end
    if (ack_dly > 0) check("rsp_hold_stable", {63'd0, hold_ok}, 64'd1);

    @(negedge clk);
    bus.fib_done = 1'b0;
    bus.rsp_ack  = 1'b1;
    m_pit_next   = !gp;
    $display("txn grant=%s k=%0d status=%0d prefix=%h len=%0d tmo=%0d",
             gp ? "pit" : "in", k, es, ep, el, m_tmo);
  endtask

  initial begin
    int          k;
    int          r;
    logic        pv;
    logic        iv;
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    m_pit_next = 1'b1;
    m_tmo    = 0;
    rst = 1'b1;
    bus.pit_req_valid = 0; bus.pit_req_prefix = '0; bus.pit_req_len = '0;
    bus.in_req_valid = 0;  bus.in_req_prefix = '0;  bus.in_req_len = '0;
    bus.fib_done = 0; bus.fib_rejected = 0; bus.fib_match_prefix = '0;
    bus.fib_match_len = '0; bus.rsp_ack = 0;
    #2;
    check("reset_ctrl", {44'd0, bus.pit_req_ready, bus.in_req_ready, bus.fib_out_bit,
          bus.fib_data_ready, bus.rsp_valid, bus.rsp_to_pit, bus.rsp_status, bus.busy,
          bus.timeout_count, bus.fib_len[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Both requesters valid: strict alternation starting with PIT.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 64'h1111_0000_0000_0000 + 64'(i), 6'd8, 64'h2222_0000_0000_0000 + 64'(i),
              6'd12, 3, 0, 64'hAAAA_0000_0000_0000, 6'd16, 0);
    // PIT lookup hit.
    run_txn(1, 0, 64'h0000FFFF0000FFFF, 6'd10, '0, '0, 2, 0, 64'h0000FFFF00000000, 6'd6, 0);
    // Incoming insert rejected.
    run_txn(0, 1, '0, '0, 64'h0000FFFF0000FFFF, 6'd10, 2, 1, 64'h1234, 6'd3, 0);
    // Response withheld while the incoming path waits; it is taken on the next IDLE.
    run_txn(1, 1, 64'hCAFE_0000_0000_0001, 6'd20, 64'hBEEF_0000_0000_0002, 6'd30,
            4, 0, 64'hCAFE_0000_0000_0000, 6'd16, 10);
    run_txn(0, 1, '0, '0, 64'hBEEF_0000_0000_0002, 6'd30, 1, 0, '0, '0, 0);
    // Timeout; fib_done arriving in the first RESP cycle is ignored.
    run_txn(1, 0, 64'h0000FFFF0000FFFF, 6'd10, '0, '0, TIMEOUT, 0, 64'h5555, 6'd1, 2);

    for (int i = 0; i < 40; i++) begin
      pv = 1'($urandom);
      iv = 1'($urandom);
      if (!pv && !iv) pv = 1'b1;
      r = int'($urandom_range(0, 9));
      k = (r < 7) ? int'($urandom_range(1, 6)) : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : 0;
      run_txn(pv, iv, {$urandom, $urandom}, 6'($urandom), {$urandom, $urandom}, 6'($urandom),
              k, 1'($urandom), {$urandom, $urandom}, 6'($urandom), int'($urandom_range(0, 3)));
    end

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 256; i++)
      run_txn(1, 0, {$urandom, $urandom}, 6'($urandom), '0, '0, 0, 0, '0, '0, 0);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    bus.rsp_ack = 1'b0;
    bus.pit_req_valid = 1'b1;
    bus.pit_req_prefix = 64'h0123_4567_89AB_CDEF;
    bus.pit_req_len = 6'd33;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", {44'd0, bus.pit_req_ready, bus.in_req_ready, bus.fib_out_bit,
          bus.fib_data_ready, bus.rsp_valid, bus.rsp_to_pit, bus.rsp_status, bus.busy,
          bus.timeout_count, bus.fib_len[0]}, 64'd0);
    check("rst_async_fib_prefix", bus.fib_prefix, 64'd0);
    check("rst_async_rsp", {bus.rsp_prefix[63:6], bus.rsp_prefix[5:0] | bus.rsp_len}, 64'd0);
    bus.pit_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pit_next = 1'b1;
    m_tmo = 0;
    run_txn(1, 0, 64'h0000FFFF0000FFFF, 6'd10, '0, '0, 2, 0, 64'h0000FFFF00000000, 6'd6, 0);
    @(negedge clk);
    bus.rsp_ack = 1'b0;
    #1;
    check("final_idle", {63'd0, bus.busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
